// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester handshakes, per-port responses and the shared ALU hookup.
interface alu_arbiter_if #(
    parameter int W = 32,
    parameter int OPW = 4
) ();
    logic           req0, req1;
    logic [OPW-1:0] op0, op1;
    logic [W-1:0]   a0, b0, a1, b1;
    logic           gnt0, gnt1;
    logic           rvalid0, rvalid1;
    logic [W-1:0]   rdata0, rdata1;
    logic           rzero0, rzero1, rerr0, rerr1;
    logic [W-1:0]   alu_a, alu_b;
    logic [OPW-1:0] alu_op;
    logic [W-1:0]   alu_f;
    logic           alu_c;

    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1, alu_f, alu_c,
        output gnt0, gnt1, rvalid0, rdata0, rzero0, rerr0,
               rvalid1, rdata1, rzero1, rerr1, alu_a, alu_b, alu_op
    );
    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1, alu_f, alu_c,
        input  gnt0, gnt1, rvalid0, rdata0, rzero0, rerr0,
               rvalid1, rdata1, rzero1, rerr1, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters,
// with a registered operand stage and registered per-port responses.
module alu_arbiter #(
    parameter int W = 32,
    parameter int OPW = 4
) (
    input logic          clk,
    input logic          rst,
    input logic          flush,
    alu_arbiter_if.slave bus
);
    localparam logic [OPW-1:0] OP_ILL = OPW'(3);

    logic           ptr, valid, owner, err;
    logic           win, any, ill, fire;
    logic [OPW-1:0] sel_op;

    // ptr=0 favours port 0
    assign bus.gnt0 = !rst && !flush && bus.req0 && (!bus.req1 || !ptr);
    assign bus.gnt1 = !rst && !flush && bus.req1 && (!bus.req0 || ptr);
    assign win      = bus.gnt1;
    assign any      = bus.gnt0 || bus.gnt1;
    assign sel_op   = win ? bus.op1 : bus.op0;
    assign ill      = sel_op == OP_ILL;
    assign fire     = valid && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= 1'b0;
            valid      <= 1'b0;
            owner      <= 1'b0;
            err        <= 1'b0;
            bus.alu_a  <= '0;
            bus.alu_b  <= '0;
            bus.alu_op <= '0;
        end else begin
            valid <= any;
            if (any) begin
                ptr        <= !win;
                owner      <= win;
                err        <= ill;
                bus.alu_op <= ill ? OPW'(0) : sel_op;
                bus.alu_a  <= ill ? W'(0) : (win ? bus.a1 : bus.a0);
                bus.alu_b  <= ill ? W'(0) : (win ? bus.b1 : bus.b0);
            end
        end
    end

    // illegal ops were turned into add(0,0); mask the resulting zero flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rvalid0 <= 1'b0;
            bus.rvalid1 <= 1'b0;
            bus.rdata0  <= '0;
            bus.rdata1  <= '0;
            bus.rzero0  <= 1'b0;
            bus.rzero1  <= 1'b0;
            bus.rerr0   <= 1'b0;
            bus.rerr1   <= 1'b0;
        end else begin
            bus.rvalid0 <= fire && !owner;
            bus.rvalid1 <= fire && owner;
            if (fire && !owner) begin
                bus.rdata0 <= err ? W'(0) : bus.alu_f;
                bus.rzero0 <= !err && bus.alu_c;
                bus.rerr0  <= err;
            end
            if (fire && owner) begin
                bus.rdata1 <= err ? W'(0) : bus.alu_f;
                bus.rzero1 <= !err && bus.alu_c;
                bus.rerr1  <= err;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: vector table plus hand sequences; responses checked against
// a queue of expected results with their due cycle.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_arbiter_if #(.W(32), .OPW(4)) bus ();
    alu_arbiter #(.W(32), .OPW(4)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // bench-side ALU: {func7[5], func3}-style codes, 0011 left unassigned
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << b[4:0];
            4'b0010: return {31'b0, $signed(a) < $signed(b)};
            4'b1011: return {31'b0, a < b};
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b1101: return $unsigned($signed(a) >>> b[4:0]);
            4'b0110: return a | b;
            4'b0111: return a & b;
            4'b1111: return b << 12;
            default: return '0;
        endcase
    endfunction
    assign bus.alu_f = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
    assign bus.alu_c = ~|bus.alu_f;

    typedef struct {
        logic        port;
        logic [3:0]  op;
        logic [31:0] a, b, d;
        logic        z, e;
    } vec_t;
    typedef struct {
        logic        port;
        logic [31:0] d;
        logic        z, e;
        int          due;
    } exp_t;

    vec_t vt[12];
    exp_t q[$];
    exp_t e;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
        end
    endtask

    task automatic set_req(input logic p, input logic r, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        if (p) begin
            bus.req1 = r; bus.op1 = o; bus.a1 = x; bus.b1 = y;
        end else begin
            bus.req0 = r; bus.op0 = o; bus.a0 = x; bus.b0 = y;
        end
    endtask

    task automatic idle();
        set_req(1'b0, 1'b0, 4'b0, 32'b0, 32'b0);
        set_req(1'b1, 1'b0, 4'b0, 32'b0, 32'b0);
    endtask

    task automatic push(input logic p, input logic [31:0] d, input logic z, input logic er);
        exp_t x;
        x.port = p; x.d = d; x.z = z; x.e = er; x.due = cyc + 2;
        q.push_back(x);
    endtask

    task automatic chk_gnt(input logic g0, input logic g1);
        chk("gnt0", 32'(bus.gnt0), 32'(g0));
        chk("gnt1", 32'(bus.gnt1), 32'(g1));
    endtask

    task automatic stage_chk(input vec_t v);
        chk("alu_a", bus.alu_a, v.e ? 32'b0 : v.a);
        chk("alu_b", bus.alu_b, v.e ? 32'b0 : v.b);
        chk("alu_op", 32'(bus.alu_op), v.e ? 32'b0 : 32'(v.op));
    endtask

    // response monitor
    always begin
        @(posedge clk);
        #1;
        if (!rst) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rmissing port=%0d due=%0d now=%0d", q[0].port, q[0].due, cyc);
                void'(q.pop_front());
            end
            if (bus.rvalid0 || bus.rvalid1) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL runexpected rvalid0=%b rvalid1=%b exp=none now=%0d", bus.rvalid0, bus.rvalid1, cyc);
                end else begin
                    e = q.pop_front();
                    chk("rboth", 32'(bus.rvalid0 & bus.rvalid1), 32'b0);
                    chk("rport", 32'(bus.rvalid1), 32'(e.port));
                    chk("rdue", 32'(cyc), 32'(e.due));
                    chk("rdata", e.port ? bus.rdata1 : bus.rdata0, e.d);
                    chk("rzero", 32'(e.port ? bus.rzero1 : bus.rzero0), 32'(e.z));
                    chk("rerr", 32'(e.port ? bus.rerr1 : bus.rerr0), 32'(e.e));
                end
            end
        end
    end

    initial begin
        vt[0]  = '{1'b0, 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 4'b1011, 32'd1, 32'd2, 32'd1, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 4'b1101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 4'b0100, 32'hF, 32'hF, 32'd0, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 4'b0011, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1};
        vt[5]  = '{1'b0, 4'b0000, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 4'b0001, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 4'b1000, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1};
        vt[9]  = '{1'b0, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0};
        vt[10] = '{1'b1, 4'b0111, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0};
        vt[11] = '{1'b1, 4'b1111, 32'd0, 32'd1, 32'h0000_1000, 1'b0, 1'b0};

        idle();
        set_req(1'b0, 1'b1, 4'b0000, 32'd5, 32'd7);
        #2;
        chk_gnt(1'b0, 1'b0);
        chk("rst_alu_a", bus.alu_a, 32'b0);
        chk("rst_alu_op", 32'(bus.alu_op), 32'b0);
        chk("rst_rvalid0", 32'(bus.rvalid0), 32'b0);
        chk("rst_rdata0", bus.rdata0, 32'b0);
        @(posedge clk);
        #1;
        chk_gnt(1'b0, 1'b0);
        chk("rst_alu_b", bus.alu_b, 32'b0);
        @(negedge clk);
        rst = 1'b0;
        idle();

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i > 0) stage_chk(vt[i-1]);
            idle();
            set_req(vt[i].port, 1'b1, vt[i].op, vt[i].a, vt[i].b);
            #1;
            chk_gnt(!vt[i].port, vt[i].port);
            push(vt[i].port, vt[i].d, vt[i].z, vt[i].e);
        end
        @(negedge clk);
        stage_chk(vt[11]);
        idle();
        repeat (3) @(negedge clk);

        // both requesting: alternate grants starting at port 0
        set_req(1'b0, 1'b1, 4'b1000, 32'd9, 32'd9);
        set_req(1'b1, 1'b1, 4'b1111, 32'd0, 32'd1);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk_gnt(c % 2 == 0, c % 2 == 1);
            if (c % 2 == 0) push(1'b0, 32'd0, 1'b1, 1'b0);
            else push(1'b1, 32'h0000_1000, 1'b0, 1'b0);
        end
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);

        // flush discards the op granted the cycle before and keeps the pointer
        set_req(1'b0, 1'b1, 4'b0000, 32'd1, 32'd1);
        #1;
        chk_gnt(1'b1, 1'b0);
        @(negedge clk);
        flush = 1'b1;
        set_req(1'b1, 1'b1, 4'b1111, 32'd0, 32'd2);
        #1;
        chk_gnt(1'b0, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk_gnt(1'b0, 1'b1);
        push(1'b1, 32'h0000_2000, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);

        // async reset with an op in the stage and a response on the outputs
        set_req(1'b0, 1'b1, 4'b0000, 32'd10, 32'd20);
        #1;
        chk_gnt(1'b1, 1'b0);
        push(1'b0, 32'd30, 1'b0, 1'b0);
        @(negedge clk);
        set_req(1'b0, 1'b1, 4'b0000, 32'd2, 32'd3);
        #1;
        chk_gnt(1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_rvalid0", 32'(bus.rvalid0), 32'b0);
        chk("arst_alu_a", bus.alu_a, 32'b0);
        chk("arst_alu_b", bus.alu_b, 32'b0);
        chk("arst_gnt0", 32'(bus.gnt0), 32'b0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_req(1'b0, 1'b1, 4'b0000, 32'd4, 32'd4);
        set_req(1'b1, 1'b1, 4'b0000, 32'd1, 32'd0);
        #1;
        chk_gnt(1'b1, 1'b0);
        push(1'b0, 32'd8, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        repeat (5) @(negedge clk);
        chk("qempty", 32'(q.size()), 32'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
